// File: rtl/upsample_if.sv
// Handshake bundle between the 4x downsampler output and the 112x112 upsampled stream.
// The DUT takes the slave view; the upstream/downstream pair takes the master view.
interface upsample_if #(
   parameter int CNT_W = 7
);
   logic             down_data;
   logic             down_data_vld;
   logic             down_data_rdy;
   logic             up_data;
   logic             up_data_vld;
   logic             up_rdy;
   logic [CNT_W-1:0] col_cnt;
   logic [CNT_W-1:0] row_cnt;
   logic             frame_done;

   modport master (
      output down_data, down_data_vld, up_rdy,
      input  down_data_rdy, up_data, up_data_vld, col_cnt, row_cnt, frame_done
   );

   modport slave (
      input  down_data, down_data_vld, up_rdy,
      output down_data_rdy, up_data, up_data_vld, col_cnt, row_cnt, frame_done
   );
endinterface

// File: rtl/upsample.sv
// Nearest-neighbour 4x upsampler: buffers one 28-pixel source line, then replays
// it as four 112-beat output rows before accepting the next line.
module upsample #(
   parameter int SRC_W = 28,
   parameter int SCALE = 4,
   parameter int CNT_W = 7,
   parameter int IDX_W = 5
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   upsample_if.slave   bus
);
   localparam int DST_W      = SRC_W * SCALE;
   localparam int LOG2_SCALE = $clog2(SCALE);

   typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [SRC_W-1:0] line_buf_r;
   logic [IDX_W-1:0] wr_idx_r;
   logic [IDX_W-1:0] rd_idx_s;
   logic [CNT_W-1:0] col_cnt_r;
   logic [CNT_W-1:0] row_cnt_r;
   logic [CNT_W-1:0] col_nxt_s;
   logic [CNT_W-1:0] row_nxt_s;
   logic             up_data_r;
   logic             up_data_vld_r;
   logic             frame_done_r;
   logic             down_data_rdy_s;
   logic             rd_bit_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic             last_px_s;
   logic             col_last_s;
   logic             row_last_s;
   logic             line_end_s;
   logic             frame_end_s;

   assign in_xfer_s   = bus.down_data_vld && down_data_rdy_s;
   assign out_xfer_s  = up_data_vld_r && bus.up_rdy;
   assign last_px_s   = (wr_idx_r == IDX_W'(SRC_W - 1));
   assign col_last_s  = (col_cnt_r == CNT_W'(DST_W - 1));
   assign row_last_s  = (row_cnt_r == CNT_W'(DST_W - 1));
   assign line_end_s  = out_xfer_s && col_last_s &&
                        (row_cnt_r[LOG2_SCALE-1:0] == LOG2_SCALE'(SCALE - 1));
   assign frame_end_s = out_xfer_s && col_last_s && row_last_s;

   // State register
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_r <= FILL;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: fill one line, then emit its four replicas
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FILL: begin
            if (in_xfer_s && last_px_s) state_nxt_s = EMIT;
            else                        state_nxt_s = FILL;
         end
         EMIT: begin
            if (line_end_s) state_nxt_s = FILL;
            else            state_nxt_s = EMIT;
         end
         default: state_nxt_s = FILL;
      endcase
   end

   // Output decode: ready is combinational so it reads 1 throughout reset
   always_comb begin
      down_data_rdy_s = 1'b0;
      case (state_r)
         FILL:    down_data_rdy_s = 1'b1;
         EMIT:    down_data_rdy_s = 1'b0;
         default: down_data_rdy_s = 1'b0;
      endcase
   end

   // Line buffer write (data storage, intentionally not reset)
   always_ff @(posedge sclk) begin
      if (in_xfer_s) begin
         line_buf_r[wr_idx_r] <= bus.down_data;
      end
   end

   // Write index
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_idx_r <= '0;
      end else if (in_xfer_s) begin
         wr_idx_r <= last_px_s ? '0 : wr_idx_r + IDX_W'(1);
      end
   end

   // Next output counter values
   always_comb begin
      col_nxt_s = col_cnt_r;
      row_nxt_s = row_cnt_r;
      if (out_xfer_s) begin
         if (col_last_s) begin
            col_nxt_s = '0;
            if (row_last_s) row_nxt_s = '0;
            else            row_nxt_s = row_cnt_r + CNT_W'(1);
         end else begin
            col_nxt_s = col_cnt_r + CNT_W'(1);
            row_nxt_s = row_cnt_r;
         end
      end else begin
         col_nxt_s = col_cnt_r;
         row_nxt_s = row_cnt_r;
      end
   end

   // Source pixel for the next beat, bypassing a same-cycle buffer write
   always_comb begin
      rd_idx_s = IDX_W'(col_nxt_s >> LOG2_SCALE);
      if (in_xfer_s && (rd_idx_s == wr_idx_r)) begin
         rd_bit_s = bus.down_data;
      end else begin
         rd_bit_s = line_buf_r[rd_idx_s];
      end
   end

   // Registered output stage
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         col_cnt_r     <= '0;
         row_cnt_r     <= '0;
         up_data_r     <= 1'b0;
         up_data_vld_r <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         col_cnt_r     <= col_nxt_s;
         row_cnt_r     <= row_nxt_s;
         up_data_r     <= (state_nxt_s == EMIT) ? rd_bit_s : 1'b0;
         up_data_vld_r <= (state_nxt_s == EMIT);
         frame_done_r  <= frame_end_s;
      end
   end

   assign bus.down_data_rdy = down_data_rdy_s;
   assign bus.up_data       = up_data_r;
   assign bus.up_data_vld   = up_data_vld_r;
   assign bus.col_cnt       = col_cnt_r;
   assign bus.row_cnt       = row_cnt_r;
   assign bus.frame_done    = frame_done_r;
endmodule

// File: tb/tb_upsample.sv
// Scoreboard bench for upsample: each completed source line queues its 448
// expected beats; an independent monitor pops and compares every output transfer.
module tb_upsample;
   localparam int SRC_W = 28;
   localparam int SCALE = 4;
   localparam int DST_W = 112;
   localparam int CNT_W = 7;

   typedef struct packed {
      logic             d;
      logic [CNT_W-1:0] c;
      logic [CNT_W-1:0] r;
   } beat_t;

   logic  sclk = 1'b0;
   logic  s_rst_n;
   beat_t exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    rdy_mode = 0;
   int    line_no = 0;
   int    fd_seen = 0;
   bit    hold_vld = 1'b0;
   bit    fd_pend, fill_pend, stall_pend;
   logic  prev_d;
   logic [CNT_W-1:0] prev_c, prev_r;

   upsample_if #(.CNT_W(CNT_W)) bus ();

   upsample dut (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .bus     (bus)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Downstream ready pattern: 0 = always, 1 = toggle, 2 = random
   initial begin
      bus.up_rdy = 1'b1;
      forever begin
         @(posedge sclk);
         #1;
         case (rdy_mode)
            0:       bus.up_rdy = 1'b1;
            1:       bus.up_rdy = ~bus.up_rdy;
            default: bus.up_rdy = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor
   initial begin
      beat_t e;
      fd_pend = 0; fill_pend = 0; stall_pend = 0;
      forever begin
         @(negedge sclk);
         if (s_rst_n !== 1'b1) begin
            fd_pend = 0; fill_pend = 0; stall_pend = 0;
         end else begin
            if (bus.frame_done === 1'b1) fd_seen++;
            if (fd_pend || bus.frame_done !== 1'b0) begin
               check("frame_done", bus.frame_done, fd_pend);
               fd_pend = 0;
            end
            if (fill_pend) begin
               check("line_end_vld", bus.up_data_vld, 0);
               check("line_end_rdy", bus.down_data_rdy, 1);
               fill_pend = 0;
            end
            if (stall_pend) begin
               check("stall_vld", bus.up_data_vld, 1);
               check("stall_data", bus.up_data, prev_d);
               check("stall_col", bus.col_cnt, prev_c);
               check("stall_row", bus.row_cnt, prev_r);
               stall_pend = 0;
            end
            if (bus.up_data_vld === 1'b1) begin
               check("emit_rdy", bus.down_data_rdy, 0);
               if (bus.up_rdy) begin
                  check("beat_expected", (exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("up_data", bus.up_data, e.d);
                     check("col_cnt", bus.col_cnt, e.c);
                     check("row_cnt", bus.row_cnt, e.r);
                     if (e.c == CNT_W'(DST_W - 1) && e.r[1:0] == 2'd3) fill_pend = 1;
                     if (e.c == CNT_W'(DST_W - 1) && e.r == CNT_W'(DST_W - 1)) fd_pend = 1;
                  end
               end else begin
                  stall_pend = 1;
                  prev_d = bus.up_data;
                  prev_c = bus.col_cnt;
                  prev_r = bus.row_cnt;
               end
            end
         end
      end
   end

   task automatic do_reset();
      s_rst_n = 1'b0;
      bus.down_data_vld = 1'b0;
      #1;
      check("rst_up_data", bus.up_data, 0);
      check("rst_up_vld", bus.up_data_vld, 0);
      check("rst_col", bus.col_cnt, 0);
      check("rst_row", bus.row_cnt, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_down_rdy", bus.down_data_rdy, 1);
      exp_q.delete();
      fd_pend = 0; fill_pend = 0; stall_pend = 0;
      line_no = 0;
      repeat (2) @(posedge sclk);
      #3;
      s_rst_n = 1'b1;
      @(posedge sclk);
      #1;
   endtask

   task automatic send_px(input logic b);
      int n = 0;
      bus.down_data     = b;
      bus.down_data_vld = 1'b1;
      forever begin
         @(negedge sclk);
         if (bus.down_data_rdy === 1'b1) begin
            @(posedge sclk);
            #1;
            break;
         end
         @(posedge sclk);
         #1;
         n++;
         if (n > 4000) begin
            check("accept_timeout", n, 0);
            break;
         end
      end
      if (!hold_vld) bus.down_data_vld = 1'b0;
   endtask

   task automatic send_line(input logic [SRC_W-1:0] px, input bit gaps);
      beat_t e;
      for (int i = 0; i < SRC_W; i++) begin
         if (gaps && !hold_vld) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge sclk);
               #1;
            end
         end
         send_px(px[i]);
      end
      for (int r = 0; r < SCALE; r++) begin
         for (int c = 0; c < DST_W; c++) begin
            e.d = px[c / SCALE];
            e.c = CNT_W'(c);
            e.r = CNT_W'(line_no * SCALE + r);
            exp_q.push_back(e);
         end
      end
      line_no = (line_no + 1) % SRC_W;
      @(negedge sclk);
      check("first_beat_latency", bus.up_data_vld, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 6000) begin
         @(posedge sclk);
         n++;
      end
      check("drain_remaining", exp_q.size(), 0);
      repeat (3) @(posedge sclk);
      #1;
   endtask

   initial begin
      int n;
      bus.down_data     = 1'b0;
      bus.down_data_vld = 1'b0;
      s_rst_n           = 1'b1;
      #2;
      do_reset();

      // reset while a line is half filled
      for (int i = 0; i < 10; i++) send_px(1'($urandom_range(0, 1)));
      do_reset();

      // alternating line: each row reads 1111 0000 x14
      rdy_mode = 0;
      send_line(28'h5555555, 1'b0);
      drain();

      // backpressure: toggling then random ready
      rdy_mode = 1;
      send_line(28'h5555555, 1'b1);
      drain();
      rdy_mode = 2;
      send_line(28'hA3C59E1, 1'b1);
      drain();

      // full frame of random data
      do_reset();
      fd_seen  = 0;
      rdy_mode = 2;
      for (int l = 0; l < SRC_W; l++) send_line(28'($urandom()), 1'b1);
      drain();
      check("frame_done_pulses", fd_seen, 1);
      check("post_frame_col", bus.col_cnt, 0);
      check("post_frame_row", bus.row_cnt, 0);

      // valid held high through EMIT
      rdy_mode = 0;
      hold_vld = 1'b1;
      send_line(28'h0F0F0F0, 1'b0);
      send_line(28'hE000007, 1'b0);
      hold_vld = 1'b0;
      bus.down_data_vld = 1'b0;
      drain();

      // reset while emitting at row 2, col 50
      do_reset();
      rdy_mode = 2;
      send_line(28'hFFFFFFF, 1'b1);
      n = 0;
      while (n < 3000) begin
         @(negedge sclk);
         if (bus.up_data_vld === 1'b1 && bus.row_cnt == 7'd2 && bus.col_cnt == 7'd50) break;
         n++;
      end
      check("reach_row2_col50", (n < 3000), 1);
      #2;
      do_reset();
      send_line(28'h1234567, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/upsample.md
Name: upsample

Overview:
- Inverse of the 4x binary downsampler. Takes the 28x28 binary feature image (one bit per beat) and rebuilds a 112x112 binary stream by nearest-neighbour replication, 4x horizontally and 4x vertically.
- Feeds the 112x112 overlay/display path and loops back for checking against the original binarised frame.
- Output rate is 16x the input rate, so both sides carry valid/ready handshakes. A one-line buffer sits between them.

Parameters:
- SRC_W, 28, source image width and height in pixels.
- SCALE, 4, replication factor per axis; must be a power of two.
- DST_W, SRC_W*SCALE = 112, output width and height (derived; do not override).
- CNT_W, 7, width of the output column and row counters; must satisfy 2^CNT_W >= DST_W.
- IDX_W, 5, width of the line-buffer write index; must satisfy 2^IDX_W >= SRC_W.

Ports:
- sclk  in  1  system clock; single clock domain.
- s_rst_n  in  1  asynchronous, active-low reset.
- down_data  in  1  source pixel.
- down_data_vld  in  1  source pixel valid.
- down_data_rdy  out  1  block accepts a source pixel this cycle.
- up_data  out  1  replicated output pixel.
- up_data_vld  out  1  output pixel valid.
- up_rdy  in  1  downstream accepts output pixel.
- col_cnt  out  CNT_W  output column of the current up_data beat (0..DST_W-1).
- row_cnt  out  CNT_W  output row of the current up_data beat (0..DST_W-1).
- frame_done  out  1  one-cycle pulse after the last beat of a frame.

Behaviour:
- Interface: one clock, sclk. Reset s_rst_n is asynchronous and active-low; all state clears immediately on assertion.
- Storage: line_buf, SRC_W x 1 bit, not reset. Write index wr_idx is IDX_W bits.
- FSM, two states, resets to FILL:
  - FILL: down_data_rdy=1, decoded combinationally from state, so it reads 1 during reset. Input transfer occurs when down_data_vld && down_data_rdy; it writes line_buf[wr_idx] and increments wr_idx. The transfer with wr_idx==SRC_W-1 sets wr_idx to 0 and moves to EMIT.
  - EMIT: down_data_rdy=0. Upstream holds its data; nothing is consumed. up_data_vld=1 for the whole state.
- Output transfer occurs when up_data_vld && up_rdy. On each transfer:
  - col_cnt increments.
  - At col_cnt==DST_W-1, col_cnt wraps to 0 and row_cnt increments.
  - If that wrap happens with row_cnt[1:0]==SCALE-1 (last replica of the line), move to FILL.
  - If it also happens with row_cnt==DST_W-1, row_cnt wraps to 0 and frame_done=1 on the next cycle.
- While up_data_vld=1: up_data == line_buf[col_cnt/SCALE].
- Stall: with up_rdy=0, up_data, up_data_vld, col_cnt and row_cnt hold unchanged.
- Registered outputs: up_data, up_data_vld, col_cnt, row_cnt, frame_done. up_data is looked up from the next-cycle counter value.
- Latency:
  - First output beat is valid the cycle after the 28th source pixel is accepted.
  - After the final beat of a line's 4th replica, up_data_vld=0 and down_data_rdy=1 on the next cycle.
  - There is no input/output overlap; the single buffer is intentional.
- Beat counts: exactly SCALE*DST_W = 448 output beats per source line and 12544 per frame.
- Reset values:
  - up_data=0, up_data_vld=0, col_cnt=0, row_cnt=0, frame_done=0.
  - wr_idx=0, state=FILL, down_data_rdy=1.
- Reset mid-operation: the partial line or frame is discarded. The next accepted pixel is source (0,0) and output restarts at row 0, col 0.
- Boundary rules:
  - down_data_vld during EMIT is ignored.
  - up_rdy during FILL is don't-care.
  - frame_done is never asserted together with up_data_vld on a beat whose col_cnt/row_cnt are both 0 of a new frame. It only follows the last transfer.

Test Plan:
- Reset check: assert s_rst_n=0 mid-stream -> all outputs 0, down_data_rdy=1 at once. After release the counters start at 0.
- Single line: feed 28 pixels 1,0,1,0... back-to-back with up_rdy=1 -> up_data_vld rises the cycle after the 28th accept. Expect 448 contiguous beats, rows 0..3 each 1111 0000 repeated 14 times. Then up_data_vld=0 and down_data_rdy=1.
- Backpressure: same line with up_rdy toggling 1/0 every cycle and random bursts -> exactly 448 beats, none lost or duplicated. up_data, col_cnt and row_cnt stay stable during stalls.
- Full frame: 784 random bits with random gaps on down_data_vld -> 12544 beats, each beat (r,c) == src[r/4][c/4]. frame_done is a single pulse the cycle after the beat at row 111, col 111, and counters return to 0.
- Input hold during EMIT: keep down_data_vld=1 continuously -> down_data_rdy=0 through all 448 beats. The pixel held by upstream is consumed only on the first FILL cycle.
- Reset in EMIT at row 2, col 50 -> outputs clear immediately. A freshly fed line emits from row 0, col 0 with its new data.
